// File: rtl/spi_ram_seq_pkg.sv
// spi_ram_seq_pkg: command and state encodings shared by the SPI RAM sequencer.
package spi_ram_seq_pkg;

    localparam int CMD_W = 2;

    typedef enum logic [CMD_W-1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_RD_OUT = 1'b1
    } state_e;

endpackage

// File: rtl/spi_ram_seq_mem.sv
// spi_ram_seq_mem: single-port synchronous RAM with write enable and a
// registered, enable-gated read port (read data holds between reads).
module spi_ram_seq_mem #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic                 re,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [ADDR_SIZE-1:0] wdata,
    output logic [ADDR_SIZE-1:0] rdata
);

    logic [ADDR_SIZE-1:0] mem [MEM_DEPTH];

    // Array write port.
    // NOTE: the storage array is kept out of reset so it can map onto RAM; only the read register is reset.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    // Registered read port; updates only on an enabled read.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/spi_ram_seq.sv
// spi_ram_seq: command decoder / sequencer between the SPI slave rx and tx
// sides. Tracks address phases, rejects out-of-order or out-of-range data
// accesses, and counts rejects in a saturating counter.
// Optional burst mode: define SPI_RAM_AUTO_INC_EN to keep the address flags
// armed and post-increment the address (wrapping at MEM_DEPTH) after each
// accepted data access.
module spi_ram_seq
    import spi_ram_seq_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [ADDR_SIZE+CMD_W-1:0] din,
    input  logic                       rx_valid,
    output logic [ADDR_SIZE-1:0]       dout,
    output logic                       tx_valid,
    output logic                       wr_addr_done,
    output logic                       rd_addr_done,
    output logic                       proto_err,
    output logic [ERR_CNT_W-1:0]       err_count
);

    cmd_e                 cmd;
    logic [ADDR_SIZE-1:0] payload;
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic                 wr_ok;
    logic                 rd_ok;
    logic                 reject;
    state_e               state;

    assign cmd     = cmd_e'(din[ADDR_SIZE+CMD_W-1 -: CMD_W]);
    assign payload = din[ADDR_SIZE-1:0];

    function automatic logic in_range(input logic [ADDR_SIZE-1:0] a);
        return 32'(a) < 32'(MEM_DEPTH);
    endfunction

`ifdef SPI_RAM_AUTO_INC_EN
    function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
        if (32'(a) == 32'(MEM_DEPTH - 1)) return '0;
        return a + ADDR_SIZE'(1);
    endfunction
`endif

    // Classify the current command as an accepted access or a reject.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        wr_ok  = 1'b0;
        rd_ok  = 1'b0;
        reject = 1'b0;
        if (rx_valid) begin
            unique case (cmd)
                CMD_WR_DATA: begin
                    wr_ok  = wr_addr_done && in_range(wr_addr);
                    reject = !wr_ok;
                end
                CMD_RD_DATA: begin
                    rd_ok  = rd_addr_done && in_range(rd_addr);
                    reject = !rd_ok;
                end
                default: ;
            endcase
        end
    end

    // Single port: only one command per cycle, so the write address wins when writing.
    assign mem_addr = wr_ok ? wr_addr : rd_addr;

    spi_ram_seq_mem #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_ok),
        .re    (rd_ok),
        .addr  (mem_addr),
        .wdata (payload),
        .rdata (dout)
    );

    // Address registers and their armed flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr      <= '0;
            rd_addr      <= '0;
            wr_addr_done <= 1'b0;
            rd_addr_done <= 1'b0;
        end else if (rx_valid) begin
            unique case (cmd)
                CMD_WR_ADDR: begin
                    wr_addr      <= payload;
                    wr_addr_done <= 1'b1;
                end
                CMD_RD_ADDR: begin
                    rd_addr      <= payload;
                    rd_addr_done <= 1'b1;
                end
`ifdef SPI_RAM_AUTO_INC_EN
                CMD_WR_DATA: if (wr_ok) wr_addr <= next_addr(wr_addr);
                CMD_RD_DATA: if (rd_ok) rd_addr <= next_addr(rd_addr);
`else
                CMD_WR_DATA: if (wr_ok) wr_addr_done <= 1'b0;
                CMD_RD_DATA: if (rd_ok) rd_addr_done <= 1'b0;
`endif
                default: ;
            endcase
        end
    end

    // Read pipeline FSM: ST_RD_OUT is the cycle dout is presented with tx_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE:   state <= rd_ok ? ST_RD_OUT : ST_IDLE;
                ST_RD_OUT: state <= rd_ok ? ST_RD_OUT : ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    assign tx_valid = (state == ST_RD_OUT);

    // Protocol-error pulse and saturating reject counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proto_err <= 1'b0;
            err_count <= '0;
        end else begin
            proto_err <= reject;
            if (reject && (err_count != '1)) err_count <= err_count + ERR_CNT_W'(1);
        end
    end

endmodule
